// File: rtl/warp_imem_arbiter.sv
// warp_imem_arbiter
//
// Shares the single icache read port between two requesters. Port 0 is the
// fetch unit and port 1 is an auxiliary reader such as debug or the loader.
// At most one memory transaction is outstanding at a time. Each port holds at
// most one pending request. Every response is steered back to the port that
// issued the request.
//
// Build option:
//   WARP_IMEM_ARB_RR_EN - round-robin arbitration when both ports compete.
//                         When undefined, port 0 has fixed priority.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_ren0/1, i_raddr0/1  one-cycle request pulse and address, per port
//   o_valid0/1, o_rdata0/1 response strobe and data, per port (data 0 when idle)
//   o_mem_ren, o_mem_raddr registered request pulse and held address to memory
//   i_mem_valid, i_mem_rdata memory response
//   o_err                 sticky protocol-violation flag
module warp_imem_arbiter #(
    parameter logic [63:0] RESET_ADDR = 64'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ren0,
    input  logic [63:0] i_raddr0,
    input  logic        i_ren1,
    input  logic [63:0] i_raddr1,
    output logic        o_valid0,
    output logic [63:0] o_rdata0,
    output logic        o_valid1,
    output logic [63:0] o_rdata1,
    output logic        o_mem_ren,
    output logic [63:0] o_mem_raddr,
    input  logic        i_mem_valid,
    input  logic [63:0] i_mem_rdata,
    output logic        o_err
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state_reg, state_next;
    logic             owner_reg, owner_next;
    logic [1:0]       pend_v_reg, pend_v_next;
    logic [1:0][63:0] pend_a_reg, pend_a_next;
    logic             mem_ren_reg, mem_ren_next;
    logic [63:0]      mem_raddr_reg, mem_raddr_next;
    logic             err_reg, err_next;

    logic [1:0]       ren;
    logic [1:0][63:0] req_addr;
    logic [1:0]       owns;
    logic [1:0]       viol;
    logic [1:0]       accept;
    logic [1:0]       cand;
    logic [1:0][63:0] cand_addr;
    logic             busy;
    logic             free;
    logic             grant;
    logic             winner;
    logic [1:0]       valid;

    assign ren      = {i_ren1, i_ren0};
    assign req_addr = {i_raddr1, i_raddr0};
    assign busy     = (state_reg == BUSY);
    assign free     = !busy || i_mem_valid;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic PORT = (gi == 1);
            // The owner may re-request in its own response cycle; that is the
            // back-to-back path and is legal.
            assign owns[gi]      = busy && (owner_reg == PORT) && !i_mem_valid;
            assign viol[gi]      = ren[gi] && (pend_v_reg[gi] || owns[gi]);
            assign accept[gi]    = ren[gi] && !viol[gi];
            assign cand[gi]      = pend_v_reg[gi] || accept[gi];
            assign cand_addr[gi] = pend_v_reg[gi] ? pend_a_reg[gi] : req_addr[gi];
        end
    endgenerate

    assign grant = free && (|cand);

`ifdef WARP_IMEM_ARB_RR_EN
    logic last_reg, last_next;

    // On a tie the port that did not win last time goes first.
    assign winner    = (&cand) ? !last_reg : cand[1];
    assign last_next = grant ? winner : last_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_reg <= 1'b1;
        end else begin
            last_reg <= last_next;
        end
    end
`else
    // Fixed priority: port 1 wins only when port 0 has nothing.
    assign winner = !cand[0];
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            pend_v_reg    <= '0;
            pend_a_reg    <= '0;
            mem_ren_reg   <= 1'b0;
            mem_raddr_reg <= RESET_ADDR;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            pend_v_reg    <= pend_v_next;
            pend_a_reg    <= pend_a_next;
            mem_ren_reg   <= mem_ren_next;
            mem_raddr_reg <= mem_raddr_next;
            err_reg       <= err_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        pend_v_next    = pend_v_reg;
        pend_a_next    = pend_a_reg;
        mem_ren_next   = 1'b0;
        mem_raddr_next = mem_raddr_reg;
        err_next       = err_reg || (|viol) || (i_mem_valid && !busy);

        // Park every accepted request. The winner's slot is cleared below, so
        // only the loser's request actually remains pending.
        for (int p = 0; p < 2; p++) begin
            if (accept[p]) begin
                pend_v_next[p] = 1'b1;
                pend_a_next[p] = req_addr[p];
            end
        end

        if (free) begin
            if (grant) begin
                state_next          = BUSY;
                owner_next          = winner;
                mem_ren_next        = 1'b1;
                mem_raddr_next      = cand_addr[winner];
                pend_v_next[winner] = 1'b0;
            end else begin
                state_next = IDLE;
            end
        end
    end

    // Output logic: responses are routed combinationally to the owner.
    always_comb begin
        valid = '0;
        if (busy && i_mem_valid) begin
            valid[owner_reg] = 1'b1;
        end
    end

    assign o_valid0    = valid[0];
    assign o_valid1    = valid[1];
    assign o_rdata0    = valid[0] ? i_mem_rdata : 64'h0;
    assign o_rdata1    = valid[1] ? i_mem_rdata : 64'h0;
    assign o_mem_ren   = mem_ren_reg;
    assign o_mem_raddr = mem_raddr_reg;
    assign o_err       = err_reg;

endmodule
